clk_div_multi: RTL and testbench

- Parametrised multi-channel integer clock divider running entirely in the single system clock domain.
- Each of NUM_CH channels generates a registered divided clock `clk_out` (duty ≈ 50%, odd ratios supported) and a one-cycle `tick` clock-enable.
- A valid/ready config port reprograms each channel's divisor at runtime; the change is glitch-free because it is applied only at the channel's period boundary.
- Feeds peripheral timing (pixel clock, UART/baud enables) and replaces hard-wired fixed-ratio dividers.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_multi_if.sv | 16 +
 rtl/clk_div_chan.sv | 83 ++++++++
 rtl/clk_div_multi.sv | 44 ++++
 tb/tb_clk_div_multi.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned DEF_CNT_W = 16;

  // Number of high cycles in a period of d cycles: ceil(d/2), overflow-free.
  function automatic logic [31:0] half_hi(input logic [31:0] d);
    return (d >> 1) + {31'd0, d[0]};
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor configuration port: valid/ready request carrying channel and divisor.
interface clk_div_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, single-entry pending divisor, output flops.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] d_act, d_act_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] pend_d, pend_d_nx;
  logic             pend_v, pend_v_nx;
  logic             clk_out_nx, tick_nx;

  // A channel holds at most one outstanding update.
  assign cfg_ready = ~pend_v;

  // Next-state: count within the period, apply pending divisor only at a wrap.
  always_comb begin
    d_act_nx   = d_act;
    cnt_nx     = cnt;
    pend_v_nx  = pend_v;
    pend_d_nx  = pend_d;
    clk_out_nx = 1'b0;
    tick_nx    = 1'b0;

    if (32'(d_act) < MIN_DIV) begin
      // Disabled: outputs low, counter frozen; a new divisor loads pre-wrapped.
      if (pend_v) begin
        d_act_nx  = pend_d;
        cnt_nx    = pend_d - CNT_W'(1);
        pend_v_nx = 1'b0;
      end
    end else if (cnt == d_act - CNT_W'(1)) begin
      cnt_nx = '0;
      if (pend_v) begin
        d_act_nx  = pend_d;
        pend_v_nx = 1'b0;
      end
      if (32'(d_act_nx) >= MIN_DIV) begin
        clk_out_nx = 1'b1;
        tick_nx    = 1'b1;
      end
    end else begin
      cnt_nx     = cnt + CNT_W'(1);
      clk_out_nx = (32'(cnt) + 32'd1) < half_hi(32'(d_act));
    end

    // Accept only happens while nothing is pending, so it never races an apply.
    if (cfg_we) begin
      pend_v_nx = 1'b1;
      pend_d_nx = cfg_div;
    end
  end

  // State register; reset starts one cycle before a wrap at the default divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_act   <= CNT_W'(DEF_DIV);
      cnt     <= CNT_W'(DEF_DIV - 1);
      pend_v  <= 1'b0;
      pend_d  <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      d_act   <= d_act_nx;
      cnt     <= cnt_nx;
      pend_v  <= pend_v_nx;
      pend_d  <= pend_d_nx;
      clk_out <= clk_out_nx;
      tick    <= tick_nx;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with runtime, period-aligned divisor updates.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  clk_div_multi_if.slave    cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_we;

  // Out-of-range channel indices are always ready and simply dropped.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(cfg.cfg_ch) == k) cfg.cfg_ready = ch_ready[k];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = cfg.cfg_valid && (32'(cfg.cfg_ch) == i) && ch_ready[i];

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (ch_we[i]),
      .cfg_div   (cfg.cfg_div),
      .cfg_ready (ch_ready[i]),
      .clk_out   (clk_out[i]),
      .tick      (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: per-edge vector table plus out-of-range channel check.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clk_out2, tick2;
  logic [2:0] clk_out3, tick3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clk_div_multi_if #(.NUM_CH(2), .CNT_W(16)) if2 ();
  clk_div_multi_if #(.NUM_CH(3), .CNT_W(16)) if3 ();

  clk_div_multi #(.NUM_CH(2), .CNT_W(16), .DEF_DIV(4)) dut (
    .clk(clk), .rst(rst), .cfg(if2), .clk_out(clk_out2), .tick(tick2)
  );

  clk_div_multi #(.NUM_CH(3), .CNT_W(16), .DEF_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .cfg(if3), .clk_out(clk_out3), .tick(tick3)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic        ch;
    logic [15:0] div;
    logic        chk_rdy;
    logic        rdy;
    logic [1:0]  clk;
    logic [1:0]  tick;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic c, input logic [15:0] d,
                              input logic cr, input logic rd, input logic [1:0] ck, input logic [1:0] tk);
    vec_t x;
    x.rst = r; x.valid = v; x.ch = c; x.div = d;
    x.chk_rdy = cr; x.rdy = rd; x.clk = ck; x.tick = tk;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    if2.cfg_valid = 1'b0; if2.cfg_ch = 1'b0;  if2.cfg_div = 16'd0;
    if3.cfg_valid = 1'b0; if3.cfg_ch = 2'd0;  if3.cfg_div = 16'd0;

    // reset, then default divide-by-4 on both channels (edges 1..8)
    tbl.push_back(mk(1,0,0,0, 0,0, 2'b00,2'b00));
    tbl.push_back(mk(1,0,0,0, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b11));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b11));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b00,2'b00));
    // ch0 <- 5 accepted on a wrap edge (9), applied at next wrap (13)
    tbl.push_back(mk(0,1,0,5, 1,1, 2'b11,2'b11));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b11,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b11,2'b11));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b01,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b10,2'b10));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b01));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b01,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b01,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b10,2'b10));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b10,2'b00));
    // edge 23: ch0 <- 7 pending, edge 24: reset discards it, 25..: back to /4
    tbl.push_back(mk(0,1,0,7, 1,1, 2'b01,2'b01));
    tbl.push_back(mk(1,0,0,0, 1,0, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b11));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b00));
    // edge 27: ch0 <- 6 at cnt=1; edge 28: ch1 <- 3 while ch0 pending
    tbl.push_back(mk(0,1,0,6, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,1,1,3, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b11,2'b11));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b00));
    tbl.push_back(mk(0,0,1,0, 1,1, 2'b01,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b10,2'b10));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b10,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b11));
    // edge 36: ch0 <- 0, disabled from wrap at 41
    tbl.push_back(mk(0,1,0,0, 1,1, 2'b11,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b01,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b10,2'b10));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b10,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b10,2'b10));
    // edge 42: ch0 <- 2 while disabled; loads at 43, first tick at 44
    tbl.push_back(mk(0,1,0,2, 1,1, 2'b10,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b11,2'b11));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b10,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b01,2'b01));
    // edge 47: ch0 <- 1, disabled from wrap at 48
    tbl.push_back(mk(0,1,0,1, 1,1, 2'b10,2'b10));
    tbl.push_back(mk(0,0,0,0, 1,0, 2'b10,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b00,2'b00));
    tbl.push_back(mk(0,0,0,0, 1,1, 2'b10,2'b10));

    for (int i = 0; i < tbl.size(); i++) begin
      rst           = tbl[i].rst;
      if2.cfg_valid = tbl[i].valid;
      if2.cfg_ch    = tbl[i].ch;
      if2.cfg_div   = tbl[i].div;
      #1;
      if (tbl[i].chk_rdy)
        chk($sformatf("cfg_ready v%0d", i), 32'(if2.cfg_ready), 32'(tbl[i].rdy));
      step();
      chk($sformatf("clk_out v%0d", i), 32'(clk_out2), 32'(tbl[i].clk));
      chk($sformatf("tick v%0d", i), 32'(tick2), 32'(tbl[i].tick));
    end

    // out-of-range channel on the 3-channel instance: always ready, no effect
    rst = 1'b1;
    if2.cfg_valid = 1'b0;
    step();
    chk("rst clk_out2", 32'(clk_out2), 32'd0);
    chk("rst clk_out3", 32'(clk_out3), 32'd0);
    chk("rst tick3", 32'(tick3), 32'd0);
    rst = 1'b0;
    if3.cfg_valid = 1'b1;
    if3.cfg_ch    = 2'd3;
    if3.cfg_div   = 16'd9;
    #1;
    chk("oor ready", 32'(if3.cfg_ready), 32'd1);
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("oor clk_out e%0d", k + 1), 32'(clk_out3), ((k % 4) < 2) ? 32'h7 : 32'h0);
      chk($sformatf("oor tick e%0d", k + 1), 32'(tick3), ((k % 4) == 0) ? 32'h7 : 32'h0);
      chk($sformatf("oor ready e%0d", k + 1), 32'(if3.cfg_ready), 32'd1);
    end
    if3.cfg_valid = 1'b0;
    if3.cfg_ch    = 2'd2;
    #1;
    chk("ch2 ready", 32'(if3.cfg_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
